// File: rtl/mmmu_bridge_if.sv
// MMMU bridge bus: arbiter handshake, host pad lanes and the framed receive path.
// The package carries the on-chip meta encoding shared by the bridge and its users.

package mmmu_bridge_pkg;
    localparam int META_W = 3;

    typedef enum logic [META_W-1:0] {
        META_NONE         = 3'd0,
        cacheline_rd_req  = 3'd1,
        cacheline_wb      = 3'd2,
        SPMLEN_spm_wb     = 3'd3,
        cacheline_rd_resp = 3'd4,
        SPMLEN_spm_write  = 3'd5
    } dbus_meta_t;

    // cyc0 frame layout for the 32-bit bus: meta in the top bits, address below
    typedef struct packed {
        dbus_meta_t  on_chip_meta;
        logic [28:0] addr;
    } dbus_pkt_cyc0_t;
endpackage

interface mmmu_bridge_if #(
    parameter int BRIDGE_WIDTH = 32
);
    import mmmu_bridge_pkg::*;

    logic                    arb_vld;
    logic [BRIDGE_WIDTH-1:0] arb_pkt;
    logic                    bridge_ack;
    logic                    bridge_fin;
    dbus_meta_t              bridge_type;
    logic [BRIDGE_WIDTH-1:0] recv_data;
    logic                    recv_data_vld;
    logic [BRIDGE_WIDTH-1:0] pad_din;
    logic                    pad_din_vld;
    logic                    pad_grant;
    logic [BRIDGE_WIDTH-1:0] pad_dout;
    logic                    pad_dout_vld;
    logic                    proto_err;

    // bridge side
    modport master (
        input  arb_vld, arb_pkt, pad_din, pad_din_vld, pad_grant,
        output bridge_ack, bridge_fin, bridge_type, recv_data, recv_data_vld,
               pad_dout, pad_dout_vld, proto_err
    );

    // arbiter + host side
    modport slave (
        output arb_vld, arb_pkt, pad_din, pad_din_vld, pad_grant,
        input  bridge_ack, bridge_fin, bridge_type, recv_data, recv_data_vld,
               pad_dout, pad_dout_vld, proto_err
    );
endinterface

// File: rtl/mmmu_bridge.sv
// Off-chip framing stage behind the MMMU arbiter. Owns the single pad bus:
// host frames (read responses, SPM writes) always win over on-chip requests.
// Outputs are decoded combinationally from the state register so an async
// reset drops every output in the same cycle.

module mmmu_bridge
    import mmmu_bridge_pkg::*;
#(
    parameter int BRIDGE_WIDTH = 32,
    parameter int CL_BEATS     = 8,
    parameter int SPM_BEATS    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mmmu_bridge_if.master bus
);

    localparam int MAX_BEATS = (CL_BEATS > SPM_BEATS) ? CL_BEATS : SPM_BEATS;
    localparam int CW        = $clog2(MAX_BEATS + 2);

    typedef logic [CW-1:0] cnt_t;

    // index of the final beat (len-1) for each transaction kind
    localparam cnt_t LAST_RD_REQ  = cnt_t'(0);
    localparam cnt_t LAST_CL_WB   = cnt_t'(CL_BEATS);
    localparam cnt_t LAST_SPM_WB  = cnt_t'(SPM_BEATS);
    localparam cnt_t LAST_RD_RESP = cnt_t'(CL_BEATS - 1);
    localparam cnt_t LAST_SPM_WR  = cnt_t'(SPM_BEATS);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_OWN, ST_PASS} state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    cnt_t       last_q, last_d;
    dbus_meta_t meta_q, meta_d;
    logic       err_q, err_d;

    dbus_meta_t host_meta, arb_meta;
    logic       host_legal;
    cnt_t       host_last, arb_last;

    logic                    ack, fin, dout_vld, rx_vld;
    logic [BRIDGE_WIDTH-1:0] dout, rx_data;
    dbus_meta_t              btype;

    assign host_meta = dbus_meta_t'(bus.pad_din[BRIDGE_WIDTH-1 -: META_W]);
    assign arb_meta  = dbus_meta_t'(bus.arb_pkt[BRIDGE_WIDTH-1 -: META_W]);

    // host cyc0 decode: only read responses and SPM writes may start a PASS
    always_comb begin
        host_legal = 1'b0;
        host_last  = '0;
        case (host_meta)
            cacheline_rd_resp: begin host_legal = 1'b1; host_last = LAST_RD_RESP; end
            SPMLEN_spm_write:  begin host_legal = 1'b1; host_last = LAST_SPM_WR;  end
            default: ;
        endcase
    end

    // on-chip request length; an unknown arbiter meta is sent as a single beat
    always_comb begin
        arb_last = LAST_RD_REQ;
        case (arb_meta)
            cacheline_wb:  arb_last = LAST_CL_WB;
            SPMLEN_spm_wb: arb_last = LAST_SPM_WB;
            default: ;
        endcase
    end

    // state, beat counter, latched transaction and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            meta_q  <= META_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            meta_q  <= meta_d;
            err_q   <= err_d;
        end
    end

    // next-state and output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        meta_d   = meta_q;
        err_d    = err_q;
        ack      = 1'b0;
        fin      = 1'b0;
        btype    = META_NONE;
        dout     = '0;
        dout_vld = 1'b0;
        rx_data  = '0;
        rx_vld   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.pad_din_vld) begin
                    // host frame consumes the cycle even if arb_vld is also up
                    if (host_legal) begin
                        state_d = ST_PASS;
                        cnt_d   = '0;
                        last_d  = host_last;
                        meta_d  = host_meta;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.arb_vld) begin
                    state_d = ST_REQ;
                end
            end

            ST_REQ: begin
                dout     = bus.arb_vld ? bus.arb_pkt : '0;
                dout_vld = bus.arb_vld;
                if (bus.pad_din_vld) begin
                    // host priority: a grant in this cycle is not honoured
                    if (host_legal) begin
                        state_d = ST_PASS;
                        cnt_d   = '0;
                        last_d  = host_last;
                        meta_d  = host_meta;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (!bus.arb_vld) begin
                    state_d = ST_IDLE;
                end else if (bus.pad_grant) begin
                    ack     = 1'b1;
                    btype   = arb_meta;
                    state_d = ST_OWN;
                    cnt_d   = '0;
                    last_d  = arb_last;
                    meta_d  = arb_meta;
                end
            end

            ST_OWN: begin
                // host sinks at full rate, so one beat leaves every cycle
                dout     = bus.arb_pkt;
                dout_vld = 1'b1;
                btype    = meta_q;
                if (cnt_q == last_q) begin
                    fin     = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    meta_d  = META_NONE;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end

            ST_PASS: begin
                rx_data = bus.pad_din;
                rx_vld  = bus.pad_din_vld;
                btype   = meta_q;
                if (bus.pad_din_vld) begin
                    if (cnt_q == last_q) begin
                        fin     = 1'b1;
                        state_d = bus.arb_vld ? ST_REQ : ST_IDLE;
                        cnt_d   = '0;
                        meta_d  = META_NONE;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.bridge_ack    = ack;
    assign bus.bridge_fin    = fin;
    assign bus.bridge_type   = btype;
    assign bus.pad_dout      = dout;
    assign bus.pad_dout_vld  = dout_vld;
    assign bus.recv_data     = rx_data;
    assign bus.recv_data_vld = rx_vld;
    assign bus.proto_err     = err_q;

endmodule

// File: tb/tb_mmmu_bridge.sv
// Bench for mmmu_bridge: cycle vectors with expected handshake outputs, a
// receive-data scoreboard, and a hand-written async reset in the middle of OWN.

module tb_mmmu_bridge;
    import mmmu_bridge_pkg::*;

    localparam int W   = 32;
    localparam int CL  = 8;
    localparam int SPM = 16;

    typedef struct {
        logic          arb_vld;
        logic [W-1:0]  arb_pkt;
        logic          din_vld;
        logic [W-1:0]  din;
        logic          grant;
        logic          ack;
        logic          fin;
        logic [2:0]    typ;
        logic          dvld;
        logic [W-1:0]  dout;
        logic          rvld;
        logic          err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mmmu_bridge_if #(.BRIDGE_WIDTH(W)) bus();

    mmmu_bridge #(.BRIDGE_WIDTH(W), .CL_BEATS(CL), .SPM_BEATS(SPM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    vec_t         tbl[$];
    logic [W-1:0] rx_q[$];

    function automatic logic [W-1:0] frm(input dbus_meta_t m, input logic [28:0] a);
        return {m, a};
    endfunction

    task automatic chk(input string name, input int idx, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic av, input logic [W-1:0] ap, input logic dv, input logic [W-1:0] d,
                       input logic g, input logic a, input logic f, input dbus_meta_t t,
                       input logic ov, input logic [W-1:0] o, input logic rv, input logic e);
        vec_t v;
        v.arb_vld = av; v.arb_pkt = ap; v.din_vld = dv; v.din = d; v.grant = g;
        v.ack = a; v.fin = f; v.typ = t; v.dvld = ov; v.dout = o; v.rvld = rv; v.err = e;
        tbl.push_back(v);
    endtask

    task automatic idle(input logic e);
        add(0, '0, 0, '0, 0, 0, 0, META_NONE, 0, '0, 0, e);
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [W-1:0] want;
        bus.arb_vld     = v.arb_vld;
        bus.arb_pkt     = v.arb_pkt;
        bus.pad_din_vld = v.din_vld;
        bus.pad_din     = v.din;
        bus.pad_grant   = v.grant;
        if (v.rvld) rx_q.push_back(v.din);
        @(negedge clk);
        chk("ack",      idx, W'(bus.bridge_ack),    W'(v.ack));
        chk("fin",      idx, W'(bus.bridge_fin),    W'(v.fin));
        chk("type",     idx, W'(bus.bridge_type),   W'(v.typ));
        chk("dout_vld", idx, W'(bus.pad_dout_vld),  W'(v.dvld));
        chk("recv_vld", idx, W'(bus.recv_data_vld), W'(v.rvld));
        chk("proto_err",idx, W'(bus.proto_err),     W'(v.err));
        if (v.dvld) chk("dout", idx, bus.pad_dout, v.dout);
        if (bus.recv_data_vld) begin
            if (rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL recv_unexpected vec=%0d got=%h want=none", idx, bus.recv_data);
            end else begin
                want = rx_q.pop_front();
                chk("recv_data", idx, bus.recv_data, want);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},  0, W'(bus.bridge_ack),    '0);
        chk({tag, "_fin"},  0, W'(bus.bridge_fin),    '0);
        chk({tag, "_type"}, 0, W'(bus.bridge_type),   '0);
        chk({tag, "_dvld"}, 0, W'(bus.pad_dout_vld),  '0);
        chk({tag, "_dout"}, 0, bus.pad_dout,          '0);
        chk({tag, "_rvld"}, 0, W'(bus.recv_data_vld), '0);
        chk({tag, "_rdat"}, 0, bus.recv_data,         '0);
        chk({tag, "_err"},  0, W'(bus.proto_err),     '0);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i], i);
        tbl.delete();
    endtask

    initial begin
        logic [W-1:0] f_rd, f_wb, f_swb, h_rr, h_sw, h_bad;
        int v;
        f_rd  = frm(cacheline_rd_req,  29'h0000_1040);
        f_wb  = frm(cacheline_wb,      29'h0000_2080);
        f_swb = frm(SPMLEN_spm_wb,     29'h0000_3000);
        h_rr  = frm(cacheline_rd_resp, 29'h0000_1040);
        h_sw  = frm(SPMLEN_spm_write,  29'h0000_4000);
        h_bad = frm(cacheline_wb,      29'h0000_5000);

        bus.arb_vld = 0; bus.arb_pkt = '0; bus.pad_din_vld = 0; bus.pad_din = '0; bus.pad_grant = 0;

        // reset state
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // rd_req: grant on cycle 2, single address beat on cycle 3
        add(1, f_rd, 0, '0, 0, 0, 0, META_NONE,        0, '0,            0, 0);
        add(1, f_rd, 0, '0, 0, 0, 0, META_NONE,        1, f_rd,          0, 0);
        add(1, f_rd, 0, '0, 1, 1, 0, cacheline_rd_req, 1, f_rd,          0, 0);
        add(1, 32'hA000_0040, 0, '0, 0, 0, 1, cacheline_rd_req, 1, 32'hA000_0040, 0, 0);
        idle(0);

        // cacheline_wb: address + 8 data beats, fin on the 9th
        add(1, f_wb, 0, '0, 0, 0, 0, META_NONE,    0, '0,   0, 0);
        add(1, f_wb, 0, '0, 1, 1, 0, cacheline_wb, 1, f_wb, 0, 0);
        for (int k = 0; k <= CL; k++)
            add(1, 32'hB000_0000 + W'(k), 0, '0, 0, 0, (k == CL), cacheline_wb,
                1, 32'hB000_0000 + W'(k), 0, 0);
        idle(0);

        // rd_resp: 8 beats with two idle gaps, fin on the 8th valid beat
        add(0, '0, 1, h_rr, 0, 0, 0, META_NONE, 0, '0, 0, 0);
        v = 0;
        for (int c = 0; c < CL + 2; c++) begin
            if (c == 2 || c == 6) begin
                add(0, '0, 0, 32'hDEAD_BEEF, 0, 0, 0, cacheline_rd_resp, 0, '0, 0, 0);
            end else begin
                add(0, '0, 1, 32'hC000_0000 + W'(v), 0, 0, (v == CL - 1), cacheline_rd_resp, 0, '0, 1, 0);
                v++;
            end
        end
        idle(0);

        // collision: host SPM write beats arb_vld, then REQ resumes and is granted
        add(1, f_swb, 1, h_sw, 0, 0, 0, META_NONE, 0, '0, 0, 0);
        for (int k = 0; k <= SPM; k++)
            add(1, f_swb, 1, 32'h5000_0000 + W'(k), 0, 0, (k == SPM), SPMLEN_spm_write, 0, '0, 1, 0);
        add(1, f_swb, 0, '0, 0, 0, 0, META_NONE,     1, f_swb, 0, 0);
        add(1, f_swb, 0, '0, 1, 1, 0, SPMLEN_spm_wb, 1, f_swb, 0, 0);
        for (int k = 0; k <= SPM; k++)
            add(1, 32'h6000_0000 + W'(k), 0, '0, 0, 0, (k == SPM), SPMLEN_spm_wb,
                1, 32'h6000_0000 + W'(k), 0, 0);
        idle(0);

        // host frame in REQ coincident with grant: no ack, PASS, then back to REQ
        add(1, f_rd, 0, '0,   0, 0, 0, META_NONE, 0, '0,   0, 0);
        add(1, f_rd, 1, h_rr, 1, 0, 0, META_NONE, 1, f_rd, 0, 0);
        for (int k = 0; k < CL; k++)
            add(1, f_rd, 1, 32'h7000_0000 + W'(k), 1, 0, (k == CL - 1), cacheline_rd_resp, 0, '0, 1, 0);
        add(1, f_rd, 0, '0, 1, 1, 0, cacheline_rd_req, 1, f_rd, 0, 0);
        add(1, 32'hA000_0080, 0, '0, 0, 0, 1, cacheline_rd_req, 1, 32'hA000_0080, 0, 0);
        idle(0);

        // bad host meta in IDLE: sticky proto_err, no receive data
        add(0, '0, 1, h_bad, 0, 0, 0, META_NONE, 0, '0, 0, 0);
        idle(1);
        add(0, '0, 1, frm(META_NONE, 29'h1), 0, 0, 0, META_NONE, 0, '0, 0, 1);
        idle(1);
        idle(1);

        run_table();

        // async reset in OWN at beat 3 of a cacheline_wb
        add(1, f_wb, 0, '0, 0, 0, 0, META_NONE,    0, '0,   0, 1);
        add(1, f_wb, 0, '0, 1, 1, 0, cacheline_wb, 1, f_wb, 0, 1);
        for (int k = 0; k < 3; k++)
            add(1, 32'hE000_0000 + W'(k), 0, '0, 0, 0, 0, cacheline_wb, 1, 32'hE000_0000 + W'(k), 0, 1);
        run_table();
        bus.arb_pkt = 32'hE000_0003;
        #2;
        chk("pre_rst_dvld", 0, W'(bus.pad_dout_vld), W'(1'b1));
        chk("pre_rst_dout", 0, bus.pad_dout, 32'hE000_0003);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.arb_vld = 0;

        // after release the bridge is IDLE and serves a fresh request
        idle(0);
        add(1, f_rd, 0, '0, 0, 0, 0, META_NONE,        0, '0,   0, 0);
        add(1, f_rd, 0, '0, 1, 1, 0, cacheline_rd_req, 1, f_rd, 0, 0);
        add(1, 32'hA000_00C0, 0, '0, 0, 0, 1, cacheline_rd_req, 1, 32'hA000_00C0, 0, 0);
        idle(0);
        run_table();

        chk("rx_q_drained", 0, W'(rx_q.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
